// File: rtl/fp_unit_pkg.sv
// rtl/fp_unit_pkg.sv - shared FP op codes, issue states and latency table
package fp_unit_pkg;

    localparam logic [3:0] OP_ADDSUB      = 4'd0;
    localparam logic [3:0] OP_MUL         = 4'd1;
    localparam logic [3:0] OP_DIV         = 4'd2;
    localparam logic [3:0] OP_MINMAX      = 4'd3;
    localparam logic [3:0] OP_CMP         = 4'd4;
    localparam logic [3:0] OP_SGNJ        = 4'd5;
    localparam logic [3:0] OP_CONVERT     = 4'd6;
    localparam logic [3:0] OP_INT_CONVERT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Settling cycles the FPU needs for each op; 0 marks an undefined op code
    function automatic int unsigned op_latency(input logic [3:0] op, input int unsigned div_cycles);
        case (op)
            OP_ADDSUB:                   return 32'd2;
            OP_MUL:                      return 32'd3;
            OP_DIV:                      return div_cycles;
            OP_MINMAX, OP_CMP, OP_SGNJ:  return 32'd1;
            OP_CONVERT, OP_INT_CONVERT:  return 32'd2;
            default:                     return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/fp_lat_lut.sv
// rtl/fp_lat_lut.sv - op code to (latency-1, illegal) lookup
module fp_lat_lut
    import fp_unit_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 12,
    parameter int unsigned CNT_W      = 4
) (
    input  logic [3:0]       op_i,
    output logic [CNT_W-1:0] lat_m1_o,
    output logic             illegal_o
);

    // Op codes 8..15 are undefined; they bypass execution entirely
    always_comb begin
        illegal_o = op_i[3];
        lat_m1_o  = '0;
        if (!op_i[3]) begin
            lat_m1_o = CNT_W'(op_latency(op_i, DIV_CYCLES) - 32'd1);
        end
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// rtl/fp_issue_ctrl.sv - single-issue sequencer around a combinational FPU
module fp_issue_ctrl
    import fp_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned DIV_CYCLES = 12
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic [3:0]            in_req_op,
    input  logic                  in_req_fmt,
    input  logic [DATA_WIDTH-1:0] in_req_rs1,
    input  logic [DATA_WIDTH-1:0] in_req_rs2,
    input  logic [TAG_WIDTH-1:0]  in_req_tag,
    output logic [DATA_WIDTH-1:0] out_fpu_rs1,
    output logic [DATA_WIDTH-1:0] out_fpu_rs2,
    output logic [3:0]            out_fpu_op,
    output logic                  out_fpu_fmt,
    input  logic [DATA_WIDTH-1:0] in_fpu_result,
    output logic                  out_resp_valid,
    input  logic                  in_resp_ready,
    output logic [DATA_WIDTH-1:0] out_resp_data,
    output logic [TAG_WIDTH-1:0]  out_resp_tag,
    output logic                  out_resp_illegal,
    input  logic                  in_flush,
    output logic                  out_busy
);

    localparam int unsigned CNT_MAX = (DIV_CYCLES > 3) ? DIV_CYCLES : 3;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   rs1_q;
    logic [DATA_WIDTH-1:0]   rs2_q;
    logic [3:0]              op_q;
    logic                    fmt_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    illegal_q;

    logic [CNT_W-1:0]        lut_lat_m1;
    logic                    lut_illegal;

    fp_lat_lut #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lat_lut (
        .op_i      (in_req_op),
        .lat_m1_o  (lut_lat_m1),
        .illegal_o (lut_illegal)
    );

    // Issue FSM: accept in IDLE, hold operands through EXEC, present result in DONE
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            op_q        <= '0;
            fmt_q       <= 1'b0;
            tag_q       <= '0;
            resp_data_q <= '0;
            illegal_q   <= 1'b0;
        end else if (in_flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_req_valid) begin
                        rs1_q     <= in_req_rs1;
                        rs2_q     <= in_req_rs2;
                        op_q      <= in_req_op;
                        fmt_q     <= in_req_fmt;
                        tag_q     <= in_req_tag;
                        illegal_q <= lut_illegal;
                        if (lut_illegal) begin
                            resp_data_q <= '0;
                            cnt_q       <= '0;
                            state_q     <= ST_DONE;
                        end else begin
                            cnt_q   <= lut_lat_m1;
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        resp_data_q <= in_fpu_result;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (in_resp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Handshake flags decode registered state only, never the inputs
    always_comb begin
        out_req_ready  = (state_q == ST_IDLE);
        out_resp_valid = (state_q == ST_DONE);
        out_busy       = (state_q != ST_IDLE);
    end

    assign out_fpu_rs1      = rs1_q;
    assign out_fpu_rs2      = rs2_q;
    assign out_fpu_op       = op_q;
    assign out_fpu_fmt      = fmt_q;
    assign out_resp_data    = resp_data_q;
    assign out_resp_tag     = tag_q;
    assign out_resp_illegal = illegal_q;

endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Sequencer that sits between the integer pipeline and the shared combinational floating-point unit. It accepts one FP request at a time through a valid/ready handshake and registers the operands, op and format. It holds those values stable on the FPU inputs for an op-dependent number of settling cycles, then captures the FPU result. It returns the result with the request tag through a second valid/ready handshake, and supports a synchronous flush.

## Interface
Parameters:
- DATA_WIDTH, 64, operand/result width
- TAG_WIDTH, 5, destination-register tag carried with each request
- DIV_CYCLES, 12, settling cycles allotted to divide (min 1)

Ports:
- in_clk  input  1  clock, rising edge
- in_rst_n  input  1  reset; asynchronous, active-low
- in_req_valid  input  1  request present
- out_req_ready  output  1  block can accept; high only in IDLE
- in_req_op  input  4  FPU op code (0 addsub … 7 int-convert)
- in_req_fmt  input  1  0 single, 1 double
- in_req_rs1, in_req_rs2  input  DATA_WIDTH  operands
- in_req_tag  input  TAG_WIDTH  writeback tag
- out_fpu_rs1, out_fpu_rs2  output  DATA_WIDTH  registered operands to FPU
- out_fpu_op  output  4  registered op to FPU
- out_fpu_fmt  output  1  registered fmt to FPU
- in_fpu_result  input  DATA_WIDTH  FPU combinational result
- out_resp_valid  output  1  response present
- in_resp_ready  input  1  consumer accepts response
- out_resp_data  output  DATA_WIDTH  captured result
- out_resp_tag  output  TAG_WIDTH  tag of the completed request
- out_resp_illegal  output  1  op code was ≥ 8
- in_flush  input  1  abort in-flight op, drop response
- out_busy  output  1  state ≠ IDLE

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: out_req_ready=1. On in_req_valid & out_req_ready:
  - Register the op, fmt, operands and tag.
  - Load the latency counter with L-1 from the op table.
  - Go to EXEC. If op ≥ 8, go straight to DONE with data 0 and illegal=1.
- Latency table L:
  - 0 addsub: 2
  - 1 mul: 3
  - 2 div: DIV_CYCLES
  - 3 minmax: 1
  - 4 cmp: 1
  - 5 sgnj: 1
  - 6 convert: 2
  - 7 int-convert: 2
- EXEC: out_fpu_* are held constant and the counter decrements each cycle. When the counter is 0, capture in_fpu_result into out_resp_data on that edge and go to DONE.
- DONE: out_resp_valid=1. Data, tag and illegal stay stable until in_resp_ready=1. On the handshake edge, go to IDLE.
- No accept in DONE, even when a response handshake occurs in the same cycle.
- Flush: in_flush=1 in any state forces IDLE on the next edge.
  - Counter is cleared and no response is produced.
  - Flush has priority over both request accept and response handshake in the same cycle.
- out_fpu_* keep their last values in IDLE and change only on accept.
- Counter width is $clog2(max(DIV_CYCLES,3)). No wrap: the counter is only decremented while nonzero.

## Timing
- Reset, asynchronous, applied at any time including mid-op, gives:
  - State IDLE, out_req_ready=1.
  - out_resp_valid=0, out_resp_data=0, out_resp_tag=0, out_resp_illegal=0, out_busy=0.
  - out_fpu_rs1, out_fpu_rs2, out_fpu_op and out_fpu_fmt all 0; counter 0.
- Accept at edge T. EXEC occupies cycles T+1 … T+L, and the result is captured at the end of cycle T+L.
- out_resp_valid is high from cycle T+L+1.
- An illegal op gives out_resp_valid in cycle T+1.
- Minimum initiation interval is L+2 cycles: accept, L EXEC cycles, one DONE cycle with ready=1, then ready returns in the following IDLE cycle.
- out_req_ready and out_resp_valid are registered-state decodes only, with no combinational path from in_* inputs.

## Structure
- Shared package fp_unit_pkg holds:
  - Op-code localparams OP_ADDSUB … OP_INT_CONVERT.
  - State encoding IDLE/EXEC/DONE.
  - Function op_latency(op, div_cycles) returning L.
- A single natural sub-module, fp_lat_lut: a combinational op→(L-1, illegal) lookup, reused by future multi-issue variants.
- The FPU instance stays outside this block and is wired at the parent.

## Test plan
- Reset mid-EXEC of a div: assert in_rst_n=0 at cycle 5. All outputs go to 0 immediately and out_req_ready=1; on release, no response ever appears.
- Addsub, fmt=1, rs1=0x3FF0000000000000, rs2=0x4000000000000000, tag=3. FPU model returns 0x4008000000000000.
  - Required: resp_valid at T+3 with data 0x4008000000000000, tag 3.
  - out_fpu_* stable during T+1..T+2.
- Mul 2.0×3.0 with in_resp_ready held 0 for 4 cycles. Required: resp_valid from T+4, data 0x4018000000000000 held unchanged until ready, out_req_ready=0 throughout.
- Div with DIV_CYCLES=12: resp_valid exactly at T+13. Then op=9: resp_valid at T'+1 with data 0 and illegal=1.
- Flush:
  - Mul, flush at T+2: IDLE at T+3, no resp_valid.
  - Flush and req_valid together in IDLE: no accept.
  - Flush in DONE with resp_ready=1: response dropped, out_busy=0 next cycle.
- Back-to-back cmp ops with valid held high: accepts spaced exactly 3 cycles apart, tags returned in order.
